stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Command sequencer upstream of the stack's bit-lane shift registers (one lane per data bit, SIZE=DEPTH).
//  Accepts one opcode(+operand) per handshake and drives the shared en/dir and per-lane d for push/pop.
//  Reads top-of-stack from bit 0 of every lane; executes multi-cycle ops (DUP/SWAP/ADD/SUB/AND); tracks occupancy.
// PARAMETERS
//  WIDTH  4  data word width = number of shift-register lanes
//  DEPTH  8  stack depth = SIZE of each lane
// PORTS
//  clk        in   1                  single clock, all state on posedge
//  rst        in   1                  synchronous, active-high; same net also resets the lanes
//  in_valid   in   1                  command present
//  in_ready   out  1                  sequencer can accept (state==IDLE)
//  in_op      in   3                  opcode: 0 NOP,1 PUSH,2 POP,3 DUP,4 SWAP,5 ADD,6 SUB,7 AND
//  in_data    in   WIDTH              PUSH operand (ignored otherwise)
//  stk_en     out  1                  to all lanes' en
//  stk_dir    out  1                  to all lanes' dir: 1=push (shift toward MSB, d into bit0), 0=pop
//  stk_d      out  WIDTH              bit i -> lane i d
//  stk_top    in   WIDTH              bit i <- lane i q[0] (current top of stack)
//  depth      out  $clog2(DEPTH+1)    number of valid entries
//  err        out  1                  sticky underflow/overflow flag
// BEHAVIOUR
//  Reset: state=IDLE, depth=0, err=0, op/a/b/data regs=0; stk_en=0, stk_dir=0, stk_d=0, in_ready=1.
//  stk_en/stk_dir/stk_d decode registered state only (Moore); no in_* -> stk_* combinational path.
//  Handshake: accept when in_valid&&in_ready; op, data latched; in_ready low until back in IDLE.
//  Legality checked at accept on current depth: PUSH,DUP need depth<DEPTH; POP,DUP need depth>=1;
//   SWAP,ADD,SUB,AND need depth>=2. Illegal: err<=1, no stack activity, stay IDLE (in_ready stays 1).
//  NOP: accepted, stays IDLE, nothing else.
//  States and per-state drive (each state is one cycle):
//   IDLE   en=0. accept -> PUSH:S_PUSHD, POP:S_POP, DUP:S_PUSHT, SWAP/ALU:S_POPA.
//   S_PUSHD en=1 dir=1 d=data_r; depth+1 -> IDLE
//   S_PUSHT en=1 dir=1 d=stk_top;  depth+1 -> IDLE (DUP)
//   S_POP   en=1 dir=0;            depth-1 -> IDLE
//   S_POPA  en=1 dir=0; a<=stk_top; depth-1 -> S_POPB
//   S_POPB  en=1 dir=0; b<=stk_top; depth-1 -> SWAP:S_PUSHA, ALU:S_PUSHR
//   S_PUSHR en=1 dir=1 d=alu(b,a); depth+1 -> IDLE
//   S_PUSHA en=1 dir=1 d=a; depth+1 -> S_PUSHB;  S_PUSHB en=1 dir=1 d=b; depth+1 -> IDLE
//  Exceptional DUP path: S_PUSHT drives stk_d from stk_top combinationally (lane output, registered in lanes).
//  a = old top, b = old second. ADD: b+a mod 2^WIDTH; SUB: b-a mod 2^WIDTH (wraps, no flag); AND: b&a.
//  Latency accept->IDLE: PUSH/POP/DUP 1 cycle, ADD/SUB/AND 3, SWAP 4; throughput 1 op per (latency+1).
//  depth never leaves 0..DEPTH (guaranteed by legality check); err cleared only by rst.
//  rst mid-operation: abort immediately to reset values; lanes cleared by same rst, depth=0 consistent.
// STRUCTURE
//  Package stackcalc_pkg: opcode enum (3 b, values above), sequencer state enum, OP_* constants.
//  Sub-module stack_alu (combinational: op, a, b -> WIDTH result) instantiated once for S_PUSHR.
//  Lanes are instantiated by the parent, not here.
// TESTING (bench: WIDTH=4, DEPTH=8, WIDTH shift_register lanes SIZE=8 as the stack)
//  Reset, hold in_valid=0 -> in_ready=1, depth=0, err=0, stk_en=0 every cycle.
//  PUSH 3, PUSH 5, ADD -> stk_top=8, depth=1, ADD in_ready low exactly 3 cycles.
//  PUSH 2, PUSH 7, SUB -> top=0xB (2-7 wraps), err=0; then AND with depth 1 -> err=1, depth unchanged.
//  PUSH 1, PUSH 9, SWAP -> top=1, second=9 (POP then top=9), depth 2->1.
//  8x PUSH 0xF then PUSH 4 -> err=1, depth=8, top=0xF; DUP at depth 8 also rejected.
//  Assert rst during S_POPB of ADD -> next cycle IDLE, depth=0, err=0, all lanes 0.

Source files
------------

// File: rtl/stackcalc_pkg.sv
// Shared types for the stack command sequencer: opcodes, FSM states and
// the depth-based legality rule applied when a command is accepted.
package stackcalc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_ADD  = 3'd5,
        OP_SUB  = 3'd6,
        OP_AND  = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PUSHD = 4'd1,
        S_PUSHT = 4'd2,
        S_POP   = 4'd3,
        S_POPA  = 4'd4,
        S_POPB  = 4'd5,
        S_PUSHR = 4'd6,
        S_PUSHA = 4'd7,
        S_PUSHB = 4'd8
    } seq_state_e;

    // An opcode is legal only if the stack holds enough entries to read and
    // has enough room left for whatever it writes back.
    function automatic logic op_legal(input op_e op, input int unsigned depth,
                                      input int unsigned max_depth);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_PUSH:                        ok = (depth < max_depth);
            OP_POP:                         ok = (depth >= 1);
            OP_DUP:                         ok = (depth >= 1) && (depth < max_depth);
            OP_SWAP, OP_ADD, OP_SUB, OP_AND: ok = (depth >= 2);
            default:                        ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the two popped operands: a is the old top, b the old second.
module stack_alu
    import stackcalc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Results wrap modulo 2^WIDTH; no carry or borrow is reported.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Command sequencer driving the shared en/dir and per-lane d of the bit-lane
// shift-register stack; performs multi-cycle ops and tracks occupancy.
module stack_sequencer
    import stackcalc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       stk_en,
    output logic                       stk_dir,
    output logic [WIDTH-1:0]           stk_d,
    input  logic [WIDTH-1:0]           stk_top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err
);

    localparam int DW = $clog2(DEPTH+1);

    seq_state_e       state, state_n;
    op_e              op_r;
    logic [WIDTH-1:0] data_r, a_r, b_r, alu_y;
    logic [DW-1:0]    depth_r;
    logic             err_r;
    logic             cmd_legal;

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_r),
        .a  (a_r),
        .b  (b_r),
        .y  (alu_y)
    );

    assign cmd_legal = op_legal(op_e'(in_op), 32'(depth_r), DEPTH);
    assign depth     = depth_r;
    assign err       = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_r    <= OP_NOP;
            data_r  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            depth_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r   <= op_e'(in_op);
                        data_r <= in_data;
                        if (!cmd_legal) err_r <= 1'b1;
                    end
                end
                S_PUSHD, S_PUSHT, S_PUSHR, S_PUSHA, S_PUSHB: depth_r <= depth_r + DW'(1);
                S_POP:  depth_r <= depth_r - DW'(1);
                S_POPA: begin
                    a_r     <= stk_top;
                    depth_r <= depth_r - DW'(1);
                end
                S_POPB: begin
                    b_r     <= stk_top;
                    depth_r <= depth_r - DW'(1);
                end
                default: ;
            endcase
        end
    end

    // Lane controls decode the registered state only; the DUP path alone
    // routes the lane output straight back into the lanes' d inputs.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        stk_en   = 1'b0;
        stk_dir  = 1'b0;
        stk_d    = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && cmd_legal) begin
                    case (op_e'(in_op))
                        OP_PUSH:                         state_n = S_PUSHD;
                        OP_POP:                          state_n = S_POP;
                        OP_DUP:                          state_n = S_PUSHT;
                        OP_SWAP, OP_ADD, OP_SUB, OP_AND: state_n = S_POPA;
                        default:                         state_n = S_IDLE;
                    endcase
                end
            end
            S_PUSHD: begin
                stk_en = 1'b1; stk_dir = 1'b1; stk_d = data_r;
                state_n = S_IDLE;
            end
            S_PUSHT: begin
                stk_en = 1'b1; stk_dir = 1'b1; stk_d = stk_top;
                state_n = S_IDLE;
            end
            S_POP: begin
                stk_en = 1'b1;
                state_n = S_IDLE;
            end
            S_POPA: begin
                stk_en = 1'b1;
                state_n = S_POPB;
            end
            S_POPB: begin
                stk_en = 1'b1;
                state_n = (op_r == OP_SWAP) ? S_PUSHA : S_PUSHR;
            end
            S_PUSHR: begin
                stk_en = 1'b1; stk_dir = 1'b1; stk_d = alu_y;
                state_n = S_IDLE;
            end
            S_PUSHA: begin
                stk_en = 1'b1; stk_dir = 1'b1; stk_d = a_r;
                state_n = S_PUSHB;
            end
            S_PUSHB: begin
                stk_en = 1'b1; stk_dir = 1'b1; stk_d = b_r;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: word-wide model of the shift-register lanes as the
// stack, a queue-based reference model, directed scenarios and random traffic.
module tb_stack_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [WIDTH-1:0] in_data = '0;
    logic             stk_en, stk_dir;
    logic [WIDTH-1:0] stk_d, stk_top;
    logic [DW-1:0]    depth;
    logic             err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .stk_en   (stk_en),
        .stk_dir  (stk_dir),
        .stk_d    (stk_d),
        .stk_top  (stk_top),
        .depth    (depth),
        .err      (err)
    );

    // Lanes: position 0 is the top; push shifts toward deeper positions,
    // pop shifts toward the top and fills the deepest slot with zero.
    logic [WIDTH-1:0] lane [DEPTH];
    assign stk_top = lane[0];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) lane[k] <= '0;
        end else if (stk_en) begin
            if (stk_dir) begin
                for (int k = DEPTH-1; k > 0; k--) lane[k] <= lane[k-1];
                lane[0] <= stk_d;
            end else begin
                for (int k = 0; k < DEPTH-1; k++) lane[k] <= lane[k+1];
                lane[DEPTH-1] <= '0;
            end
        end
    end

    // Reference model: queue front is the top; m_busy counts cycles left
    // before the sequencer can accept again.
    logic [WIDTH-1:0] m_stk[$];
    int               m_busy = 0;
    bit               m_err  = 1'b0;

    task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] a, b, t;
        int n;
        n = m_stk.size();
        case (op)
            3'd0: ;
            3'd1: if (n < DEPTH) begin m_stk.push_front(data); m_busy = 1; end else m_err = 1'b1;
            3'd2: if (n >= 1) begin void'(m_stk.pop_front()); m_busy = 1; end else m_err = 1'b1;
            3'd3: if (n >= 1 && n < DEPTH) begin m_stk.push_front(m_stk[0]); m_busy = 1; end
                  else m_err = 1'b1;
            3'd4: if (n >= 2) begin
                      t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t; m_busy = 4;
                  end else m_err = 1'b1;
            default: if (n >= 2) begin
                      a = m_stk.pop_front();
                      b = m_stk.pop_front();
                      if (op == 3'd5)      t = WIDTH'(int'(b) + int'(a));
                      else if (op == 3'd6) t = WIDTH'(int'(b) - int'(a));
                      else                 t = b & a;
                      m_stk.push_front(t);
                      m_busy = 3;
                  end else m_err = 1'b1;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_stk.delete();
            m_busy = 0;
            m_err  = 1'b0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (in_valid) begin
            model_apply(in_op, in_data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("err", int'(err), int'(m_err));
            if (m_busy == 0) begin
                chk("ready_idle", int'(in_ready), 1);
                chk("en_idle", int'(stk_en), 0);
                chk("depth", int'(depth), m_stk.size());
                chk("top", int'(stk_top), (m_stk.size() > 0) ? int'(m_stk[0]) : 0);
                for (int k = 0; k < DEPTH; k++) begin
                    if (lane[k] != ((k < m_stk.size()) ? m_stk[k] : '0))
                        chk($sformatf("stack[%0d]", k), int'(lane[k]),
                            (k < m_stk.size()) ? int'(m_stk[k]) : 0);
                end
            end else begin
                chk("ready_busy", int'(in_ready), 0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", n, 0);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data);
        wait_idle();
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'd0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        // Reset then quiet cycles: compare process pins the idle outputs.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_depth", int'(depth), 0);
        chk("rst_en", int'(stk_en), 0);

        // 3 + 5 = 8, with the busy window measured directly.
        do_cmd(3'd1, 4'd3);
        do_cmd(3'd1, 4'd5);
        do_cmd(3'd5, 4'd0);
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("add_busy", cnt, 3);
        chk("add_top", int'(stk_top), 8);
        chk("add_depth", int'(depth), 1);

        // 2 - 7 wraps to 0xB; AND at depth 1 is rejected.
        do_reset();
        do_cmd(3'd1, 4'd2);
        do_cmd(3'd1, 4'd7);
        do_cmd(3'd6, 4'd0);
        wait_idle();
        chk("sub_top", int'(stk_top), 11);
        chk("sub_err", int'(err), 0);
        do_cmd(3'd7, 4'd0);
        wait_idle();
        chk("and_err", int'(err), 1);
        chk("and_depth", int'(depth), 1);

        // SWAP of 9 over 1, then POP exposes 9.
        do_reset();
        do_cmd(3'd1, 4'd1);
        do_cmd(3'd1, 4'd9);
        do_cmd(3'd4, 4'd0);
        wait_idle();
        chk("swap_top", int'(stk_top), 1);
        chk("swap_second", int'(lane[1]), 9);
        do_cmd(3'd2, 4'd0);
        wait_idle();
        chk("pop_top", int'(stk_top), 9);
        chk("pop_depth", int'(depth), 1);

        // Overflow: ninth PUSH and DUP at full depth both rejected.
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_cmd(3'd1, 4'hF);
        do_cmd(3'd1, 4'd4);
        wait_idle();
        chk("ovf_err", int'(err), 1);
        chk("ovf_depth", int'(depth), 8);
        chk("ovf_top", int'(stk_top), 15);
        do_cmd(3'd3, 4'd0);
        wait_idle();
        chk("dup_full_depth", int'(depth), 8);

        // Reset landing in S_POPB of an ADD.
        do_reset();
        do_cmd(3'd1, 4'd3);
        do_cmd(3'd1, 4'd5);
        do_cmd(3'd5, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_depth", int'(depth), 0);
        chk("abort_err", int'(err), 0);
        cnt = 0;
        for (int k = 0; k < DEPTH; k++) if (lane[k] != '0) cnt++;
        chk("abort_lanes", cnt, 0);

        // Random traffic, including valid held through busy windows and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_op    = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            in_data  = WIDTH'($urandom);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
